bridge_sync_fifo: RTL and testbench

Parametrised single-clock FIFO for the AXI2APB bridge request/response paths, the next generation of the bridge's basic buffering FIFO. It uses valid/ready handshakes on both sides with first-word-fall-through reads. It also provides a registered occupancy count, programmable almost-full/almost-empty flags and a synchronous flush. The block sits between the AXI slave front end and the APB master sequencer so that thresholds can drive early back-pressure and burst scheduling.

---
 rtl/bridge_sync_fifo_if.sv | 50 +++++
 rtl/bridge_sync_fifo.sv | 168 ++++++++++++++++
 tb/tb_bridge_sync_fifo.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/bridge_sync_fifo_if.sv
// ---------------------------------------------------------------------------
// bridge_sync_fifo_if
// Bundles the write side, the read side and the status outputs of
// bridge_sync_fifo. The FIFO connects through the slave modport. The
// producer/consumer logic (or a testbench) connects through the master
// modport.
//
// Handshake rule, used on both sides: a transfer happens on a rising clock
// edge where valid and ready are both 1.
//   - The FIFO drives wready_o and rvalid_o straight from registers.
//   - The FIFO never lowers a ready or a valid in response to the other
//     side's valid or ready.
//
// Signals:
//   flush_i  : synchronous flush request.
//   wvalid_i : write request.
//   wready_o : FIFO can accept a write.
//   wdata_i  : write payload.
//   rvalid_o : head entry valid.
//   rready_i : consumer takes the head entry.
//   rdata_o  : head entry (fall-through).
//   level_o  : occupancy, 0..DEPTH.
//   afull_o  : almost-full flag.
//   aempty_o : almost-empty flag.
// ---------------------------------------------------------------------------
interface bridge_sync_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LG2  = 4
);
    logic                  flush_i;
    logic                  wvalid_i;
    logic                  wready_o;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic                  rvalid_o;
    logic                  rready_i;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic [DEPTH_LG2:0]    level_o;
    logic                  afull_o;
    logic                  aempty_o;

    modport master (
        output flush_i, wvalid_i, wdata_i, rready_i,
        input  wready_o, rvalid_o, rdata_o, level_o, afull_o, aempty_o
    );

    modport slave (
        input  flush_i, wvalid_i, wdata_i, rready_i,
        output wready_o, rvalid_o, rdata_o, level_o, afull_o, aempty_o
    );
endinterface

// File: rtl/bridge_sync_fifo.sv
// ---------------------------------------------------------------------------
// bridge_sync_fifo
// Single-clock FIFO with first-word-fall-through reads. It buffers the
// AXI2APB bridge request/response paths.
//
// Features:
//   - Registered occupancy count.
//   - Registered almost-full / almost-empty flags for early back-pressure.
//   - Synchronous flush.
//
// Ports:
//   clk   : clock; all state changes on its rising edge.
//   rst_n : asynchronous active-low reset. It also clears the storage.
//   bus   : bridge_sync_fifo_if.slave. It carries the write, read and
//           status signals.
//
// Parameters:
//   DEPTH_LG2  : log2 of entry count (>= 1).
//   DATA_WIDTH : payload width.
//   AFULL_LVL  : afull_o asserts when level >= AFULL_LVL.
//   AEMPTY_LVL : aempty_o asserts when level <= AEMPTY_LVL.
// ---------------------------------------------------------------------------
module bridge_sync_fifo #(
    parameter int DEPTH_LG2  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int AFULL_LVL  = (1 << DEPTH_LG2) - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    bridge_sync_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LG2;
    localparam int PTR_W = DEPTH_LG2 + 1;

    // ------------------------------------------------------------------
    // Parameter legality, checked at elaboration
    // ------------------------------------------------------------------
    if (DEPTH_LG2 < 1) begin : g_bad_depth
        $fatal(1, "bridge_sync_fifo: DEPTH_LG2 must be >= 1");
    end
    if (AEMPTY_LVL < 0) begin : g_bad_aempty
        $fatal(1, "bridge_sync_fifo: AEMPTY_LVL must be >= 0");
    end
    if (AEMPTY_LVL >= AFULL_LVL) begin : g_bad_order
        $fatal(1, "bridge_sync_fifo: AEMPTY_LVL must be < AFULL_LVL");
    end
    if (AFULL_LVL > DEPTH) begin : g_bad_afull
        $fatal(1, "bridge_sync_fifo: AFULL_LVL must be <= DEPTH");
    end

    // Thresholds in level width. The legal range 0..DEPTH fits PTR_W bits.
    localparam logic [PTR_W-1:0] AFULL_TH  = PTR_W'(AFULL_LVL);
    localparam logic [PTR_W-1:0] AEMPTY_TH = PTR_W'(AEMPTY_LVL);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wrptr_q, wrptr_d;
    logic [PTR_W-1:0]      rdptr_q, rdptr_d;
    logic [PTR_W-1:0]      level_q, level_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;

    logic push;
    logic pop;
    logic wr_en;

    // Handshakes are qualified only by registered status. An offer into a
    // full FIFO, or a read of an empty one, is simply not a transfer.
    assign push  = bus.wvalid_i & ~full_q;
    assign pop   = bus.rready_i & ~empty_q;

    // A flush discards a same-cycle push, so the storage is not written.
    assign wr_en = push & ~bus.flush_i;

    // ------------------------------------------------------------------
    // Next-state pointers and derived status
    // ------------------------------------------------------------------
    always_comb begin
        wrptr_d = wrptr_q;
        rdptr_d = rdptr_q;

        if (bus.flush_i) begin
            wrptr_d = '0;
            rdptr_d = '0;
        end else begin
            wrptr_d = wrptr_q + PTR_W'(push);
            rdptr_d = rdptr_q + PTR_W'(pop);
        end

        // The pointers are one bit wider than the index, so equal pointers
        // mean empty. Equal index bits with different wrap bits mean full.
        empty_d  = (wrptr_d == rdptr_d);
        full_d   = (wrptr_d[DEPTH_LG2] != rdptr_d[DEPTH_LG2]) &&
                   (wrptr_d[DEPTH_LG2-1:0] == rdptr_d[DEPTH_LG2-1:0]);

        // Modular difference gives the occupancy directly, even across wraps.
        level_d  = wrptr_d - rdptr_d;
        afull_d  = (level_d >= AFULL_TH);
        aempty_d = (level_d <= AEMPTY_TH);
    end

    // ------------------------------------------------------------------
    // Status and pointer registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrptr_q  <= '0;
            rdptr_q  <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            wrptr_q  <= wrptr_d;
            rdptr_q  <= rdptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage. Reset clears it so rdata_o is deterministic (0) after reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wrptr_q[DEPTH_LG2-1:0]] <= bus.wdata_i;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.wready_o = ~full_q;
    assign bus.rvalid_o = ~empty_q;
    assign bus.rdata_o  = mem_q[rdptr_q[DEPTH_LG2-1:0]];
    assign bus.level_o  = level_q;
    assign bus.afull_o  = afull_q;
    assign bus.aempty_o = aempty_q;

`ifndef SYNTHESIS
    // These enables are gated by full/empty above. Either firing means the
    // gating has been broken.
    always @(posedge clk) begin
        if (rst_n) begin
            if (wr_en && full_q) begin
                $error("bridge_sync_fifo: write enable while full");
            end
            if (pop && empty_q) begin
                $error("bridge_sync_fifo: read enable while empty");
            end
        end
    end
`endif

endmodule

// File: tb/tb_bridge_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_bridge_sync_fifo
// Self-checking bench for bridge_sync_fifo.
//
// Configuration: DEPTH_LG2=2, AFULL_LVL=3, AEMPTY_LVL=1, 8-bit data.
//
// Reference model:
//   - An occupancy counter.
//   - An expected-data queue. A modelled push appends to it. A modelled pop
//     removes the front and compares it with rdata_o.
//
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled
// on the falling edge, or 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_bridge_sync_fifo;
    localparam int DW    = 8;
    localparam int DLG2  = 2;
    localparam int DEPTH = 1 << DLG2;
    localparam int AFULL = 3;
    localparam int AEMPT = 1;

    logic clk;
    logic rst_n;

    bridge_sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH_LG2(DLG2)) bus ();

    bridge_sync_fifo #(
        .DEPTH_LG2 (DLG2),
        .DATA_WIDTH(DW),
        .AFULL_LVL (AFULL),
        .AEMPTY_LVL(AEMPT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [DW-1:0] exp_q[$];
    int            m_level;
    int            n_checks;
    int            n_fail;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_reset_values();
        check_eq("rst_wready", 32'(bus.wready_o), 32'd1);
        check_eq("rst_rvalid", 32'(bus.rvalid_o), 32'd0);
        check_eq("rst_level",  32'(bus.level_o),  32'd0);
        check_eq("rst_afull",  32'(bus.afull_o),  32'd0);
        check_eq("rst_aempty", 32'(bus.aempty_o), 32'd1);
        check_eq("rst_rdata",  32'(bus.rdata_o),  32'd0);
    endtask

    // Compare every status output and the head entry against the model.
    task automatic check_state();
        check_eq("level",  32'(bus.level_o),  32'(m_level));
        check_eq("rvalid", 32'(bus.rvalid_o), 32'(m_level != 0));
        check_eq("wready", 32'(bus.wready_o), 32'(m_level != DEPTH));
        check_eq("afull",  32'(bus.afull_o),  32'(m_level >= AFULL));
        check_eq("aempty", 32'(bus.aempty_o), 32'(m_level <= AEMPT));
        if (m_level != 0) begin
            check_eq("head", 32'(bus.rdata_o), 32'(exp_q[0]));
        end
    endtask

    // ------------------------------------------------------------------
    // Driver: one clock cycle.
    // Entry and exit: 1 time unit after a rising edge.
    // ------------------------------------------------------------------
    task automatic cycle(input logic wv, input logic [DW-1:0] wd,
                         input logic rr, input logic fl);
        logic [DW-1:0] rd_sample;
        logic          m_push;
        logic          m_pop;
        logic [DW-1:0] exp_v;

        bus.wvalid_i = wv;
        bus.wdata_i  = wd;
        bus.rready_i = rr;
        bus.flush_i  = fl;

        m_push = wv && (m_level < DEPTH);
        m_pop  = rr && (m_level > 0);

        @(negedge clk);
        rd_sample = bus.rdata_o;
        @(posedge clk);
        #1;

        if (fl) begin
            exp_q.delete();
            m_level = 0;
        end else begin
            if (m_pop) begin
                exp_v = exp_q.pop_front();
                check_eq("pop_data", 32'(rd_sample), 32'(exp_v));
            end
            if (m_push) begin
                exp_q.push_back(wd);
            end
            m_level = m_level + int'(m_push) - int'(m_pop);
        end

        bus.wvalid_i = 1'b0;
        bus.rready_i = 1'b0;
        bus.flush_i  = 1'b0;
        check_state();
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_level  = 0;

        rst_n        = 1'b0;
        bus.flush_i  = 1'b0;
        bus.wvalid_i = 1'b0;
        bus.wdata_i  = '0;
        bus.rready_i = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First push: fall-through after one edge.
        cycle(1'b1, 8'hA1, 1'b0, 1'b0);
        check_eq("a1_data", 32'(bus.rdata_o), 32'hA1);

        // Build up entries, then reset asynchronously mid-cycle.
        cycle(1'b1, 8'hB2, 1'b0, 1'b0);
        cycle(1'b1, 8'hB3, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        exp_q.delete();
        m_level = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill to full; the fifth push is held.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        end
        cycle(1'b1, 8'h14, 1'b0, 1'b0);

        // Full with push+pop: only the pop happens.
        cycle(1'b1, 8'h14, 1'b1, 1'b0);
        cycle(1'b1, 8'h14, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Empty with push+pop: only the push happens.
        cycle(1'b1, 8'h77, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Streaming at level 2; pointers wrap several times.
        cycle(1'b1, 8'h20, 1'b0, 1'b0);
        cycle(1'b1, 8'h21, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 8'(8'h22 + i), 1'b1, 1'b0);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush priority over a simultaneous push and pop.
        cycle(1'b1, 8'h31, 1'b0, 1'b0);
        cycle(1'b1, 8'h32, 1'b0, 1'b0);
        cycle(1'b1, 8'h33, 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b1, 1'b1);
        cycle(1'b1, 8'h66, 1'b0, 1'b0);
        check_eq("post_flush_data", 32'(bus.rdata_o), 32'h66);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Read requests while empty are ignored.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Random traffic with occasional flushes.
        for (int i = 0; i < 60; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
